// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encodings, dummy address and counter width for spi_bus_arbiter
package spi_arb_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_XFER = 3'd2, S_WAIT = 3'd3, S_HOLD = 3'd4, S_GAP = 3'd5;
  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SETUP = S_SETUP,
    ST_XFER  = S_XFER,
    ST_WAIT  = S_WAIT,
    ST_HOLD  = S_HOLD,
    ST_GAP   = S_GAP
  } arb_state_e;
  localparam logic [7:0] SPI_DUMMY_ADDR = 8'hFF;
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t cnt_inc(input cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester-side and spi_master-side signals of the arbiter
interface spi_bus_arbiter_if #(parameter int N_REQ = 2) ();
  logic [N_REQ-1:0]   req, lock, grant, done, ss_n;
  logic [8*N_REQ-1:0] addr;
  logic [7:0]         rdata, spi_addr, spi_data;
  logic               timeout, spi_start, spi_busy, spi_finish;
  modport slave (input req, lock, addr, spi_busy, spi_finish, spi_data,
                 output grant, done, rdata, timeout, ss_n, spi_start, spi_addr);
  modport master (output req, lock, addr, spi_busy, spi_finish, spi_data,
                  input grant, done, rdata, timeout, ss_n, spi_start, spi_addr);
endinterface

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker; first requester after ptr (wrapping) wins
module spi_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of one spi_master byte engine with per-slave selects.
// Define SPI_ARB_WDOG_EN to revoke ownership after HOLD_TIMEOUT idle cycles in HOLD.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_GAP       = 4,
  parameter int HOLD_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  spi_bus_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef SPI_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  arb_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  cnt_t             cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d, ss_n_q, ss_n_d, done_q, done_d, pick_oh;
  logic [7:0]       rdata_q, rdata_d, spi_addr_q, spi_addr_d, addr_i;
  logic             timeout_q, timeout_d, start_q, start_d, drop_q, drop_d;
  logic             pick_valid, go_start, go_gap, req_i, lock_i;
  logic             setup_done, gap_done, hold_expired;
  spi_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(bus.req), .ptr(ptr_q), .onehot(pick_oh), .idx(pick_idx), .valid(pick_valid)
  );
  assign req_i        = bus.req[idx_q];
  assign lock_i       = bus.lock[idx_q];
  assign addr_i       = bus.addr[{idx_q, 3'b000} +: 8];
  assign setup_done   = int'(cnt_q) + 1 >= CS_SETUP;
  assign gap_done     = int'(cnt_q) + 1 >= CS_GAP;
  assign hold_expired = WDOG && (int'(cnt_q) + 1 >= HOLD_TIMEOUT);
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_inc(cnt_q);
    grant_d    = grant_q;
    ss_n_d     = ss_n_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    timeout_d  = 1'b0;
    start_d    = 1'b0;
    spi_addr_d = spi_addr_q;
    drop_d     = drop_q;
    go_start   = 1'b0;
    go_gap     = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_valid) begin
        state_d = ST_SETUP;
        idx_d   = pick_idx;
        ptr_d   = pick_idx;
        grant_d = pick_oh;
        ss_n_d  = ~pick_oh;
        cnt_d   = '0;
      end
      ST_SETUP: begin
        go_gap   = !req_i;
        go_start = req_i && setup_done && !bus.spi_busy;
      end
      ST_XFER: begin
        drop_d = drop_q | !req_i;
        if (bus.spi_finish) begin
          rdata_d = bus.spi_data;
          done_d  = grant_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (lock_i && !drop_q) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end else go_gap = 1'b1;
      ST_HOLD: if (req_i && !bus.spi_busy) go_start = 1'b1;
      else if (!lock_i) go_gap = 1'b1;
      else if (hold_expired) begin
        timeout_d = 1'b1;
        go_gap    = 1'b1;
      end
      ST_GAP: state_d = gap_done ? ST_IDLE : ST_GAP;
      default: state_d = ST_IDLE;
    endcase
    if (go_start) begin
      state_d    = ST_XFER;
      start_d    = 1'b1;
      spi_addr_d = addr_i;
      drop_d     = 1'b0;
    end
    if (go_gap) begin
      state_d = ST_GAP;
      grant_d = '0;
      ss_n_d  = '1;
      cnt_d   = '0;
    end
  end
  // Asynchronous clear so every select rises the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptr_q      <= IW'(N_REQ - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      ss_n_q     <= '1;
      done_q     <= '0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
      start_q    <= 1'b0;
      spi_addr_q <= SPI_DUMMY_ADDR;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      start_q    <= start_d;
      spi_addr_q <= spi_addr_d;
      drop_q     <= drop_d;
    end
  end
  assign bus.grant     = grant_q;
  assign bus.ss_n      = ss_n_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.timeout   = timeout_q;
  assign bus.spi_start = start_q;
  assign bus.spi_addr  = spi_addr_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed stimulus with per-requester scoreboard queues and a decoupled monitor
module tb_spi_bus_arbiter;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_bus_arbiter_if #(.N_REQ(N)) bus ();
  spi_bus_arbiter #(.N_REQ(N), .CS_SETUP(2), .CS_GAP(4), .HOLD_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int total = 0, bad = 0;
  int n_start = 0, n_done = 0, n_timeout = 0;
  logic [7:0] exp_addr [N][$];
  logic [7:0] exp_data [N][$];
  logic [7:0] plan [N][$];
  int gseq [$];
  int lat_m;
  logic [7:0] cur_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // spi_master model: 4-cycle busy, returns addr ^ 8'hF9 (8'hBB -> 8'h42)
  initial begin
    bus.spi_busy = 1'b0;
    bus.spi_finish = 1'b0;
    bus.spi_data = 8'h00;
    lat_m = 0;
    cur_m = 8'h00;
    forever begin
      @(negedge clk);
      bus.spi_finish = 1'b0;
      if (!rst) bus.spi_busy = 1'b0;
      else if (bus.spi_busy) begin
        if (lat_m == 0) begin
          bus.spi_busy = 1'b0;
          bus.spi_finish = 1'b1;
          bus.spi_data = cur_m ^ 8'hF9;
        end else lat_m--;
      end else if (bus.spi_start) begin
        bus.spi_busy = 1'b1;
        lat_m = 3;
        cur_m = bus.spi_addr;
      end
    end
  end

  // monitor: pops scoreboard on spi_start / done, checks select timing
  initial begin
    int hi_run, setup_n, since_done, o;
    bit armed;
    logic [N-1:0] prev_ss, sel;
    hi_run = 100; setup_n = 0; since_done = 100; o = 0; armed = 1'b0; prev_ss = '1; sel = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        hi_run = 100; armed = 1'b0; prev_ss = '1; since_done = 100;
      end else begin
        since_done++;
        sel = ~bus.ss_n;
        chk("ss_overlap", $countones(sel) <= 1, 1);
        if (prev_ss == '1 && bus.ss_n != '1) begin
          chk("gap_len", hi_run >= 4, 1);
          chk("grant_vs_ss", bus.grant, sel);
          gseq.push_back(oh2i(sel));
          armed = 1'b1;
          setup_n = 1;
        end else if (armed && !bus.spi_start) setup_n++;
        if (bus.spi_start) begin
          n_start++;
          chk("start_while_busy", bus.spi_busy, 0);
          if (armed) chk("setup_len", setup_n, 2);
          else chk("hold_restart", since_done, 2);
          armed = 1'b0;
          o = oh2i(bus.grant);
          if (exp_addr[o].size() == 0) chk("start_unexpected", bus.spi_start, 0);
          else chk("spi_addr", bus.spi_addr, exp_addr[o].pop_front());
        end
        if (bus.done != '0) begin
          n_done++;
          since_done = 0;
          o = oh2i(bus.done);
          chk("done_onehot", $onehot(bus.done), 1);
          chk("fin_to_done", bus.spi_finish, 1);
          if (exp_data[o].size() == 0) chk("done_unexpected", bus.done, 0);
          else chk($sformatf("rdata_req%0d", o), bus.rdata, exp_data[o].pop_front());
        end
        if (bus.timeout) n_timeout++;
        hi_run = (bus.ss_n == '1) ? hi_run + 1 : 0;
        prev_ss = bus.ss_n;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global time limit");
  end

  task automatic requester(input int i, input int nlock);
    int nb, w;
    nb = plan[i].size();
    for (int b = 0; b < nb; b++) begin
      bus.addr[8*i +: 8] = plan[i][b];
      exp_addr[i].push_back(plan[i][b]);
      exp_data[i].push_back(plan[i][b] ^ 8'hF9);
      if (b > 0) @(negedge clk);
      bus.lock[i] = (b < nlock);
      bus.req[i] = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.done[i] && w < 400);
      chk($sformatf("done_seen_req%0d", i), bus.done[i], 1);
      if (!bus.done[i]) begin
        bus.req[i] = 1'b0;
        bus.lock[i] = 1'b0;
        return;
      end
      if (b == nb - 1) bus.req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    bus.lock = '0;
    for (int i = 0; i < N; i++) begin
      exp_addr[i].delete();
      exp_data[i].delete();
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_plan(input int i, input logic [7:0] a0, input int n);
    plan[i].delete();
    for (int b = 0; b < n; b++) plan[i].push_back(a0 + 8'(b));
  endtask

  initial begin
    int s0, d0, w;
    int exp_g [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    bus.req = '0;
    bus.lock = '0;
    bus.addr = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_ss_n", bus.ss_n, 2'b11);
    chk("rst_spi_start", bus.spi_start, 0);
    chk("rst_spi_addr", bus.spi_addr, 8'hFF);
    rst = 1'b1;
    // 1: single byte from requester 0
    set_plan(0, 8'hBB, 1);
    s0 = n_start;
    requester(0, 0);
    chk("t1_done", bus.done, 2'b01);
    chk("t1_rdata", bus.rdata, 8'h42);
    chk("t1_one_start", n_start - s0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_gap_ss", bus.ss_n, 2'b11);
      chk("t1_gap_grant", bus.grant, 0);
    end
    // 2: both requesting continuously, 4 bytes each
    do_reset();
    gseq.delete();
    set_plan(0, 8'h10, 4);
    set_plan(1, 8'h20, 4);
    fork
      requester(0, 0);
      requester(1, 0);
    join
    chk("t2_grants", gseq.size(), 8);
    for (int k = 0; k < 8 && k < gseq.size(); k++) chk($sformatf("t2_grant%0d", k), gseq[k], exp_g[k]);
    // 3: locked 7-byte burst from requester 0, requester 1 waiting
    repeat (6) @(negedge clk);
    gseq.delete();
    plan[0].delete();
    for (int b = 0; b < 6; b++) plan[0].push_back(8'hBB + 8'(b));
    plan[0].push_back(8'hFF);
    set_plan(1, 8'h77, 1);
    d0 = n_done;
    fork
      requester(0, 6);
      requester(1, 0);
    join
    chk("t3_dones", n_done - d0, 8);
    chk("t3_grants", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("t3_first", gseq[0], 0);
      chk("t3_second", gseq[1], 1);
    end
    // 4: owner idles in HOLD with lock high
    repeat (6) @(negedge clk);
    gseq.delete();
    set_plan(0, 8'h30, 1);
    set_plan(1, 8'h40, 1);
    fork
      begin
        requester(0, 1);
`ifdef SPI_ARB_WDOG_EN
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.timeout && w < 50);
        chk("t4_timeout_cycle", w, 11);
        chk("t4_ss_released", bus.ss_n, 2'b11);
        chk("t4_grant_revoked", bus.grant, 0);
        @(negedge clk);
        chk("t4_timeout_pulse", bus.timeout, 0);
        bus.lock[0] = 1'b0;
`else
        repeat (40) @(negedge clk);
        chk("t4_held_grant", bus.grant, 2'b01);
        chk("t4_held_ss", bus.ss_n, 2'b10);
        chk("t4_no_timeout", n_timeout, 0);
        bus.lock[0] = 1'b0;
`endif
      end
      requester(1, 0);
    join
    chk("t4_grants", gseq.size(), 2);
    if (gseq.size() == 2) chk("t4_second", gseq[1], 1);
    // 5: reset asserted mid-transfer
    repeat (6) @(negedge clk);
    bus.addr[7:0] = 8'h55;
    exp_addr[0].push_back(8'h55);
    exp_data[0].push_back(8'h55 ^ 8'hF9);
    bus.req = 2'b01;
    w = 0;
    while (!bus.spi_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t5_busy_seen", bus.spi_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_ss_n", bus.ss_n, 2'b11);
    chk("t5_start", bus.spi_start, 0);
    chk("t5_grant", bus.grant, 0);
    chk("t5_rdata", bus.rdata, 0);
    chk("t5_spi_addr", bus.spi_addr, 8'hFF);
    exp_addr[0].delete();
    exp_data[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    set_plan(0, 8'h55, 1);
    requester(0, 0);
    // 6: requester 0 drops during SETUP
    repeat (6) @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    bus.req[0] = 1'b1;
    w = 0;
    while (bus.ss_n[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t6_selected", bus.ss_n, 2'b10);
    bus.req[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_start", n_start - s0, 0);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_ss_idle", bus.ss_n, 2'b11);
    chk("t6_grant_idle", bus.grant, 0);
    set_plan(1, 8'h99, 1);
    requester(1, 0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("drain_addr%0d", i), exp_addr[i].size(), 0);
      chk($sformatf("drain_data%0d", i), exp_data[i].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
